dmem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the shared data-memory/IO bus (addr, datain, we, dataout) of the single-cycle computer's data memory block. Master 0 is the CPU-side load/store port; master 1 is an auxiliary requester (debug/DMA loader). The arbiter grants one access at a time with round-robin fairness, drives the memory bus, waits the memory read latency, and returns read data with a one-cycle ack pulse. RAM/IO decoding (addr[7]) stays downstream and is transparent to this block.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/arb_rr2.sv | 11 +
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic          mem_we;
  logic [DW-1:0] mem_dataout;
  logic          busy;
  logic          grant_id;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_dataout,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_datain, mem_we, busy, grant_id
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_dataout,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_datain, mem_we, busy, grant_id
  );
endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the master that was not
// served last wins.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~rr_last : req[1];
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the shared data-memory bus: one access at a
// time, round-robin on ties, single-cycle ack with registered read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic           clock,
  input logic           resetn,
  dmem_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata0_q;
  logic [DW-1:0]    rdata1_q;
  logic             we_q;
  logic             gid_q;
  logic             rr_last_q;
  logic             gnt_valid;
  logic             gnt_id;

  arb_rr2 u_rr (
    .req       ({bus.m1_req, bus.m0_req}),
    .rr_last   (rr_last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // WAIT counts lat_cnt down to zero inclusive, so it always lasts
  // MEM_LATENCY cycles and an access is MEM_LATENCY+2 busy cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      we_q      <= 1'b0;
      gid_q     <= M_CPU;
      rr_last_q <= M_AUX;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gid_q   <= gnt_id;
            we_q    <= gnt_id ? bus.m1_we    : bus.m0_we;
            addr_q  <= gnt_id ? bus.m1_addr  : bus.m0_addr;
            wdata_q <= gnt_id ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        ISSUE: lat_cnt_q <= LAT_W'(MEM_LATENCY - 1);
        WAIT: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end else if (!we_q) begin
            if (gid_q == M_AUX) rdata1_q <= bus.mem_dataout;
            else                rdata0_q <= bus.mem_dataout;
          end
        end
        DONE: rr_last_q <= gid_q;
        default: ;
      endcase
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_datain = wdata_q;
  assign bus.mem_we     = (state_q == ISSUE) && we_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = gid_q;
  assign bus.m0_ack     = (state_q == DONE) && (gid_q == M_CPU);
  assign bus.m1_ack     = (state_q == DONE) && (gid_q == M_AUX);
  assign bus.m0_rdata   = rdata0_q;
  assign bus.m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (latency 1 and 3) checked every cycle
// against a transaction-level model, plus directed scenarios with literal values.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus_a ();
  dmem_arbiter_if #(.AW(32), .DW(32)) bus_b ();

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(1)) dut_a (
    .clock (clock), .resetn (resetn), .bus (bus_a));
  dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(3)) dut_b (
    .clock (clock), .resetn (resetn), .bus (bus_b));

  // Master-side stimulus, indexed [dut][master]
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];

  // DUT observations
  logic        busy_o  [2];
  logic        mwe_o   [2];
  logic        gid_o   [2];
  logic [31:0] maddr_o [2];
  logic [31:0] mdin_o  [2];
  logic        ack_o   [2][2];
  logic [31:0] rdata_o [2][2];

  assign bus_a.m0_req = req[0][0];   assign bus_a.m1_req = req[0][1];
  assign bus_a.m0_we  = we[0][0];    assign bus_a.m1_we  = we[0][1];
  assign bus_a.m0_addr = addr[0][0]; assign bus_a.m1_addr = addr[0][1];
  assign bus_a.m0_wdata = wdata[0][0]; assign bus_a.m1_wdata = wdata[0][1];
  assign bus_b.m0_req = req[1][0];   assign bus_b.m1_req = req[1][1];
  assign bus_b.m0_we  = we[1][0];    assign bus_b.m1_we  = we[1][1];
  assign bus_b.m0_addr = addr[1][0]; assign bus_b.m1_addr = addr[1][1];
  assign bus_b.m0_wdata = wdata[1][0]; assign bus_b.m1_wdata = wdata[1][1];

  assign busy_o[0] = bus_a.busy;        assign busy_o[1] = bus_b.busy;
  assign mwe_o[0] = bus_a.mem_we;       assign mwe_o[1] = bus_b.mem_we;
  assign gid_o[0] = bus_a.grant_id;     assign gid_o[1] = bus_b.grant_id;
  assign maddr_o[0] = bus_a.mem_addr;   assign maddr_o[1] = bus_b.mem_addr;
  assign mdin_o[0] = bus_a.mem_datain;  assign mdin_o[1] = bus_b.mem_datain;
  assign ack_o[0][0] = bus_a.m0_ack;    assign ack_o[0][1] = bus_a.m1_ack;
  assign ack_o[1][0] = bus_b.m0_ack;    assign ack_o[1][1] = bus_b.m1_ack;
  assign rdata_o[0][0] = bus_a.m0_rdata; assign rdata_o[0][1] = bus_a.m1_rdata;
  assign rdata_o[1][0] = bus_b.m0_rdata; assign rdata_o[1][1] = bus_b.m1_rdata;

  // Data memory: 128-word RAM below 0x80, fixed IO pattern at and above 0x80
  logic [31:0] ram [2][128];
  assign bus_a.mem_dataout = bus_a.mem_addr[7] ? {24'h0, bus_a.mem_addr[7:0] ^ 8'hD5}
                                               : ram[0][bus_a.mem_addr[6:0]];
  assign bus_b.mem_dataout = bus_b.mem_addr[7] ? {24'h0, bus_b.mem_addr[7:0] ^ 8'hD5}
                                               : ram[1][bus_b.mem_addr[6:0]];

  always @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 128; i++) ram[d][i] <= 32'hA5A5_0000 | 32'(i);
    end else begin
      if (mwe_o[0] && !maddr_o[0][7]) ram[0][maddr_o[0][6:0]] <= mdin_o[0];
      if (mwe_o[1] && !maddr_o[1][7]) ram[1][maddr_o[1][6:0]] <= mdin_o[1];
    end
  end

  // ---------------- Transaction-level reference model ----------------
  // cyc counts cycles since the grant edge: 1 = issue, lat+2 = ack cycle.
  int          cyc   [2];
  logic        e_gid [2];
  logic        e_rr  [2];
  logic        t_we  [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wd   [2];
  logic [31:0] e_rd   [2][2];
  logic [31:0] mram   [2][128];

  function automatic int lat_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic rr);
    return (r0 && r1) ? ~rr : r1;
  endfunction

  function automatic logic [31:0] mdl_rd(input int d, input logic [31:0] a);
    return a[7] ? {24'h0, a[7:0] ^ 8'hD5} : mram[d][a[6:0]];
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        cyc[d] <= 0; e_gid[d] <= 1'b0; e_rr[d] <= 1'b1; t_we[d] <= 1'b0;
        e_addr[d] <= '0; e_wd[d] <= '0; e_rd[d][0] <= '0; e_rd[d][1] <= '0;
        for (int i = 0; i < 128; i++) mram[d][i] <= 32'hA5A5_0000 | 32'(i);
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (cyc[d] == 0) begin
          if (req[d][0] || req[d][1]) begin
            e_gid[d]  <= pick(req[d][0], req[d][1], e_rr[d]);
            t_we[d]   <= pick(req[d][0], req[d][1], e_rr[d]) ? we[d][1]    : we[d][0];
            e_addr[d] <= pick(req[d][0], req[d][1], e_rr[d]) ? addr[d][1]  : addr[d][0];
            e_wd[d]   <= pick(req[d][0], req[d][1], e_rr[d]) ? wdata[d][1] : wdata[d][0];
            cyc[d]    <= 1;
          end
        end else if (cyc[d] == lat_of(d) + 2) begin
          e_rr[d] <= e_gid[d];
          cyc[d]  <= 0;
        end else begin
          if (cyc[d] == 1 && t_we[d] && !e_addr[d][7]) mram[d][e_addr[d][6:0]] <= e_wd[d];
          if (cyc[d] == lat_of(d) + 1 && !t_we[d]) e_rd[d][e_gid[d]] <= mdl_rd(d, e_addr[d]);
          cyc[d] <= cyc[d] + 1;
        end
      end
    end
  end

  // ---------------- Checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_busy", d), busy_o[d], cyc[d] != 0);
      chk($sformatf("d%0d_mem_we", d), mwe_o[d], cyc[d] == 1 && t_we[d]);
      chk($sformatf("d%0d_mem_addr", d), maddr_o[d], e_addr[d]);
      chk($sformatf("d%0d_mem_datain", d), mdin_o[d], e_wd[d]);
      chk($sformatf("d%0d_grant_id", d), gid_o[d], e_gid[d]);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("d%0d_m%0d_ack", d, m), ack_o[d][m],
            cyc[d] == lat_of(d) + 2 && e_gid[d] == 1'(m));
        chk($sformatf("d%0d_m%0d_rdata", d, m), rdata_o[d][m], e_rd[d][m]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Drives one request and waits (bounded) for its ack; returns at an IDLE negedge.
  task automatic run_txn(input int d, input int m, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int we_cnt, output int other_ack,
                         output int busy_cnt, output logic [31:0] we_addr,
                         output logic [31:0] we_data, output logic [31:0] rd);
    req[d][m] = 1'b1; we[d][m] = w; addr[d][m] = a; wdata[d][m] = wd;
    lat = -1; we_cnt = 0; other_ack = 0; busy_cnt = 0;
    we_addr = '0; we_data = '0; rd = '0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      tick();
      if (busy_o[d]) busy_cnt++;
      if (mwe_o[d]) begin we_cnt++; we_addr = maddr_o[d]; we_data = mdin_o[d]; end
      if (ack_o[d][1-m]) other_ack++;
      if (ack_o[d][m]) begin lat = n; rd = rdata_o[d][m]; req[d][m] = 1'b0; end
    end
    req[d][m] = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, wec, oth, bc, acks, both, nack;
    logic [31:0] wa, wdat, rd;
    logic [3:0] gseq;

    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
      end
    resetn = 1'b0;
    tick();
    chk("rst_busy", busy_o[0], 1'b0);
    chk("rst_grant_id", gid_o[0], 1'b0);
    chk("rst_mem_addr", maddr_o[0], 32'h0);
    chk("rst_m1_rdata", rdata_o[1][1], 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // 1: m0 write
    run_txn(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, lat, wec, oth, bc, wa, wdat, rd);
    chk("t1_ack_latency", lat, 3);
    chk("t1_we_cycles", wec, 1);
    chk("t1_we_addr", wa, 32'h10);
    chk("t1_we_data", wdat, 32'hDEADBEEF);
    chk("t1_m1_ack_count", oth, 0);

    // 2: m1 reads it back
    run_txn(0, 1, 1'b0, 32'h10, 32'h0, lat, wec, oth, bc, wa, wdat, rd);
    chk("t2_ack_latency", lat, 3);
    chk("t2_m1_rdata", rd, 32'hDEADBEEF);
    chk("t2_m0_rdata", rdata_o[0][0], 32'h0);
    chk("t2_we_cycles", wec, 0);

    // 3: both masters continuously requesting
    do_reset();
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h20;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 32'h24;
    acks = 0; both = 0; gseq = '0;
    for (int n = 0; n < 40 && acks < 4; n++) begin
      tick();
      if (ack_o[0][0] && ack_o[0][1]) both++;
      if (ack_o[0][0] || ack_o[0][1]) begin
        gseq[acks] = ack_o[0][1];
        acks++;
      end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    tick();
    chk("t3_ack_count", acks, 4);
    chk("t3_grant_seq", {28'h0, gseq}, 32'b1010);
    chk("t3_ack_overlap", both, 0);
    chk("t3_m1_rdata", rdata_o[0][1], 32'hA5A5_0024);
    tick();

    // 4: latency 3 instance, IO read
    run_txn(1, 0, 1'b0, 32'h80, 32'h0, lat, wec, oth, bc, wa, wdat, rd);
    chk("t4_ack_latency", lat, 5);
    chk("t4_m0_rdata", rd, 32'h55);
    chk("t4_busy_cycles", bc, 5);

    // 5: reset during WAIT of an m1 read
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 32'h80;
    tick();
    tick();
    chk("t5_in_wait_busy", busy_o[0], 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o[0], 1'b0);
    chk("t5_rst_mem_we", mwe_o[0], 1'b0);
    chk("t5_rst_mem_addr", maddr_o[0], 32'h0);
    chk("t5_rst_grant_id", gid_o[0], 1'b0);
    chk("t5_rst_m1_rdata", rdata_o[0][1], 32'h0);
    tick();
    chk("t5_no_m1_ack", ack_o[0][1], 1'b0);
    resetn = 1'b1;
    run_txn(0, 1, 1'b0, 32'h80, 32'h0, lat, wec, oth, bc, wa, wdat, rd);
    chk("t5_regrant_latency", lat, 3);
    chk("t5_m1_rdata", rd, 32'h55);

    // 6: m0 withdraws req mid-WAIT on the latency 3 instance
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 32'h05;
    tick();
    tick();
    req[1][0] = 1'b0;
    nack = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (ack_o[1][0]) nack++;
    end
    chk("t6_ack_pulses", nack, 1);
    chk("t6_idle_after", busy_o[1], 1'b0);
    chk("t6_m0_rdata", rdata_o[1][0], 32'hA5A5_0005);

    // Random traffic on both instances
    for (int n = 0; n < 4000; n++) begin
      tick();
      for (int d = 0; d < 2; d++)
        for (int m = 0; m < 2; m++) begin
          if (req[d][m]) begin
            if (ack_o[d][m]) begin
              if ($urandom_range(0, 1) == 1) begin
                we[d][m] = 1'($urandom_range(0, 1));
                addr[d][m] = ($urandom_range(0, 7) == 0) ? 32'h80 | $urandom_range(0, 3)
                                                         : 32'($urandom_range(0, 15));
                wdata[d][m] = $urandom;
              end else begin
                req[d][m] = 1'b0;
              end
            end
          end else if ($urandom_range(0, 3) == 0) begin
            req[d][m] = 1'b1;
            we[d][m] = 1'($urandom_range(0, 1));
            addr[d][m] = ($urandom_range(0, 7) == 0) ? 32'h80 | $urandom_range(0, 3)
                                                     : 32'($urandom_range(0, 15));
            wdata[d][m] = $urandom;
          end
        end
    end
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) req[d][m] = 1'b0;
    for (int n = 0; n < 10; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
